// File: rtl/lcd_char_ctrl_if.sv
// Byte command channel from a requester (PIO, text engine) into lcd_char_ctrl.
// valid/ready: a byte transfers on a clock edge where cmd_valid and cmd_ready are both 1.
// The requester holds cmd_valid, cmd_rs and cmd_data stable until that edge.
interface lcd_char_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_char_ctrl.sv
// HD44780 write-only sequencer: power-up delay, optional init ROM, then one enable pulse per byte.
// Define LCD_CHAR_CTRL_INIT_SEQ_EN to send the built-in 8-bit/2-line init sequence automatically.
module lcd_char_ctrl #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 4,
    parameter int T_EN_HIGH = 25,
    parameter int T_CMD     = 2500,
    parameter int T_CLEAR   = 100000
) (
    input  logic                clk,
    input  logic                rstN,
    lcd_char_ctrl_if.slave      cmd,
    input  logic                blon_in,
    output logic                init_done,
    output logic                lcd_on,
    output logic                lcd_blon,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_en,
    output logic [7:0]          lcd_d,
    output logic [2:0]          dbg_state
);

    localparam int T_MAX_A = (T_POWERUP > T_SETUP) ? T_POWERUP : T_SETUP;
    localparam int T_MAX_B = (T_EN_HIGH > T_CMD) ? T_EN_HIGH : T_CMD;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_CLEAR) ? T_MAX_C : T_CLEAR;
    localparam int CW      = $clog2(T_MAX) + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [2:0] {
        S_POWERUP, S_INIT_LOAD, S_SETUP, S_STROBE, S_WAIT, S_IDLE
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] rom_idx_q, rom_idx_d;
    logic       ready_q, ready_d;
    logic       init_done_q, init_done_d;
    logic       lcd_on_q, lcd_on_d;
    logic       blon_q, blon_d;
    logic       rs_q, rs_d;
    logic       en_q, en_d;
    logic [7:0] d_q, d_d;
    logic [7:0] rom_byte;
    logic       rom_empty;
    logic       cnt_zero;
    logic       slow_cmd;

`ifdef LCD_CHAR_CTRL_INIT_SEQ_EN
    localparam logic [2:0] ROM_LEN = 3'd6;
    always_comb begin
        case (rom_idx_q)
            3'd0:    rom_byte = 8'h38;
            3'd1:    rom_byte = 8'h38;
            3'd2:    rom_byte = 8'h38;
            3'd3:    rom_byte = 8'h0C;
            3'd4:    rom_byte = 8'h01;
            3'd5:    rom_byte = 8'h06;
            default: rom_byte = 8'h00;
        endcase
    end
`else
    localparam logic [2:0] ROM_LEN = 3'd0;
    assign rom_byte = 8'h00;
`endif

    assign rom_empty = (rom_idx_q == ROM_LEN);
    assign cnt_zero  = (cnt_q == '0);
    // Clear and home are the slow instructions; the decision uses the byte already on the bus.
    assign slow_cmd  = !rs_q && (d_q == 8'h01 || d_q == 8'h02 || d_q == 8'h03);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_idx_d   = rom_idx_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        lcd_on_d    = 1'b1;
        blon_d      = blon_in;
        rs_d        = rs_q;
        en_d        = en_q;
        d_d         = d_q;
        case (state_q)
            S_POWERUP: begin
                if (cnt_zero) state_d = S_INIT_LOAD;
                else          cnt_d   = cnt_q - 1'b1;
            end
            S_INIT_LOAD: begin
                if (rom_empty) begin
                    init_done_d = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rs_d      = 1'b0;
                    d_d       = rom_byte;
                    rom_idx_d = rom_idx_q + 3'd1;
                    cnt_d     = cnt_t'(T_SETUP - 1);
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    en_d    = 1'b1;
                    cnt_d   = cnt_t'(T_EN_HIGH - 1);
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_zero) begin
                    en_d    = 1'b0;
                    cnt_d   = slow_cmd ? cnt_t'(T_CLEAR - 1) : cnt_t'(T_CMD - 1);
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                // init_done is still low while the ROM is being played out.
                if (cnt_zero) begin
                    if (init_done_q) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_INIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    rs_d    = cmd.cmd_rs;
                    d_d     = cmd.cmd_data;
                    cnt_d   = cnt_t'(T_SETUP - 1);
                    state_d = S_SETUP;
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = cnt_t'(T_POWERUP - 1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= S_POWERUP;
            cnt_q       <= cnt_t'(T_POWERUP - 1);
            rom_idx_q   <= 3'd0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            lcd_on_q    <= 1'b0;
            blon_q      <= 1'b0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            d_q         <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_idx_q   <= rom_idx_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            lcd_on_q    <= lcd_on_d;
            blon_q      <= blon_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            d_q         <= d_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign init_done     = init_done_q;
    assign lcd_on        = lcd_on_q;
    assign lcd_blon      = blon_q;
    assign lcd_rs        = rs_q;
    assign lcd_rw        = 1'b0;
    assign lcd_en        = en_q;
    assign lcd_d         = d_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: a negedge monitor turns each accepted byte into expected pulse and
// ready times from the timing rules, and scenario tasks drive commands over the interface.
module tb_lcd_char_ctrl;
    localparam int P   = 100;
    localparam int S   = 2;
    localparam int E   = 12;
    localparam int TC  = 50;
    localparam int TCL = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       blon_in = 1'b0;
    logic       init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_d;
    logic [2:0] dbg_state;

    lcd_char_ctrl_if bus ();

    lcd_char_ctrl #(
        .T_POWERUP(P), .T_SETUP(S), .T_EN_HIGH(E), .T_CMD(TC), .T_CLEAR(TCL)
    ) dut (
        .clk(clk), .rstN(rst_n), .cmd(bus), .blon_in(blon_in),
        .init_done(init_done), .lcd_on(lcd_on), .lcd_blon(lcd_blon), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_d(lcd_d), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         exp_ready_cyc = -1;
    int         exp_done_cyc = -1;
    logic [8:0] exp_q[$];
    int         exp_rise_q[$];
    int         exp_fall_q[$];
    int         acc_cyc_q[$];

    function automatic int t_wait(input logic [8:0] p);
        logic [7:0] b;
        b = p[7:0];
        if (!p[8] && b >= 8'd1 && b <= 8'd3) return TCL;
        return TC;
    endfunction

    // Expected init pulses and init_done edge, counted in edges after reset release.
    task automatic model_init();
        int t;
        logic [7:0] rom[$];
        t = P + 1;
`ifdef LCD_CHAR_CTRL_INIT_SEQ_EN
        rom.push_back(8'h38); rom.push_back(8'h38); rom.push_back(8'h38);
        rom.push_back(8'h0C); rom.push_back(8'h01); rom.push_back(8'h06);
`endif
        foreach (rom[i]) begin
            exp_q.push_back({1'b0, rom[i]});
            exp_rise_q.push_back(t + S);
            exp_fall_q.push_back(t + S + E);
            t = t + S + E + t_wait({1'b0, rom[i]}) + 1;
        end
        exp_ready_cyc = t;
        exp_done_cyc  = t;
    endtask

    task automatic monitor();
        logic prev_en, prev_rdy, prev_done;
        logic [8:0] p;
        int r;
        prev_en = 0; prev_rdy = 0; prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; prev_en = 0; prev_rdy = 0; prev_done = 0;
                exp_q.delete(); exp_rise_q.delete(); exp_fall_q.delete();
                exp_ready_cyc = -1; exp_done_cyc = -1;
            end else begin
                cyc++;
                n_cmp++;
                if (lcd_rw !== 1'b0 || lcd_on !== 1'b1 || lcd_blon !== blon_in) begin
                    n_fail++;
                    $display("FAIL static_pins cyc=%0d rw=%b on=%b blon=%b want rw=0 on=1 blon=%b",
                             cyc, lcd_rw, lcd_on, lcd_blon, blon_in);
                end
                if (bus.cmd_valid === 1'b1 && prev_rdy) begin
                    p = {bus.cmd_rs, bus.cmd_data};
                    acc_cnt++;
                    acc_cyc_q.push_back(cyc);
                    exp_q.push_back(p);
                    exp_rise_q.push_back(cyc + S);
                    exp_fall_q.push_back(cyc + S + E);
                    exp_ready_cyc = cyc + S + E + t_wait(p);
                    n_cmp++;
                    if ({lcd_rs, lcd_d} !== p || bus.cmd_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL accept_load cyc=%0d bus=%h ready=%b want bus=%h ready=0",
                                 cyc, {lcd_rs, lcd_d}, bus.cmd_ready, p);
                    end
                end
                if (lcd_en === 1'b1 && !prev_en) begin
                    n_cmp++;
                    if (exp_rise_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pulse_unexpected cyc=%0d bus=%h want no pulse", cyc, {lcd_rs, lcd_d});
                    end else begin
                        r = exp_rise_q.pop_front();
                        if (r != cyc || {lcd_rs, lcd_d} !== exp_q[0]) begin
                            n_fail++;
                            $display("FAIL pulse_rise cyc=%0d bus=%h want cyc=%0d bus=%h",
                                     cyc, {lcd_rs, lcd_d}, r, exp_q[0]);
                        end
                    end
                end
                if (lcd_en !== 1'b1 && prev_en) begin
                    n_cmp++;
                    if (exp_fall_q.size() == 0 || exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pulse_fall_unexpected cyc=%0d want no pulse", cyc);
                    end else begin
                        r = exp_fall_q.pop_front();
                        p = exp_q.pop_front();
                        if (r != cyc || {lcd_rs, lcd_d} !== p) begin
                            n_fail++;
                            $display("FAIL pulse_fall cyc=%0d bus=%h want cyc=%0d bus=%h",
                                     cyc, {lcd_rs, lcd_d}, r, p);
                        end
                    end
                end
                if (bus.cmd_ready === 1'b1 && !prev_rdy) begin
                    n_cmp++;
                    if (cyc != exp_ready_cyc) begin
                        n_fail++;
                        $display("FAIL ready_rise cyc=%0d want cyc=%0d", cyc, exp_ready_cyc);
                    end
                    exp_ready_cyc = -1;
                end
                if (init_done !== prev_done) begin
                    n_cmp++;
                    if (init_done !== 1'b1 || cyc != exp_done_cyc) begin
                        n_fail++;
                        $display("FAIL init_done_edge cyc=%0d val=%b want rise at cyc=%0d",
                                 cyc, init_done, exp_done_cyc);
                    end
                end
                prev_en   = (lcd_en === 1'b1);
                prev_rdy  = (bus.cmd_ready === 1'b1);
                prev_done = (init_done === 1'b1);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        blon_in = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit hold);
        int start;
        int n;
        start = acc_cnt;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_rs    = rs;
        bus.cmd_data  = d;
        while (acc_cnt == start && n < 3000) begin
            step();
            n++;
        end
        n_cmp++;
        if (acc_cnt == start) begin
            n_fail++;
            $display("FAIL send_timeout byte=%h accepts=%0d want %0d", {rs, d}, acc_cnt, start + 1);
        end
        if (!hold) begin
            bus.cmd_valid = 1'b0;
            bus.cmd_rs    = 1'($urandom_range(0, 1));
            bus.cmd_data  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout ready=%b want 1 within %0d cycles", bus.cmd_ready, budget);
        end
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_init();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 0 || init_done !== 0 || lcd_on !== 0 || lcd_blon !== 0 ||
            lcd_rs !== 0 || lcd_rw !== 0 || lcd_en !== 0 || lcd_d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values rdy=%b done=%b on=%b blon=%b rs=%b rw=%b en=%b d=%h want all 0",
                     bus.cmd_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_d);
        end
        release_reset();
        wait_ready(3000);
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_level val=%b want 1", init_done);
        end
    endtask

    task automatic test_data_write();
        send(1'b1, 8'h41, 1'b0);
        wait_ready(1000);
    endtask

    task automatic test_slow_commands();
        logic [8:0] tbl[6];
        tbl = '{9'h001, 9'h101, 9'h002, 9'h003, 9'h000, 9'h004};
        foreach (tbl[i]) begin
            send(tbl[i][8], tbl[i][7:0], 1'b0);
            wait_ready(1000);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0;
        int a0;
        d0 = 8'($urandom_range(0, 255));
        a0 = acc_cyc_q.size();
        for (int i = 0; i < 3; i++) send(1'b1, d0 + 8'(i), 1'b1);
        bus.cmd_valid = 1'b0;
        wait_ready(1000);
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (acc_cyc_q.size() < a0 + 3 ||
                acc_cyc_q[a0 + i] - acc_cyc_q[a0 + i - 1] != S + E + TC + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing idx=%0d got=%0d want=%0d", i,
                         (acc_cyc_q.size() >= a0 + 3) ? acc_cyc_q[a0 + i] - acc_cyc_q[a0 + i - 1] : -1,
                         S + E + TC + 1);
            end
        end
    endtask

    task automatic test_random();
        logic rs;
        logic [7:0] d;
        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            send(rs, d, 1'b0);
            if ($urandom_range(0, 1) == 1) wait_ready(1000);
            repeat ($urandom_range(0, 5)) step();
        end
        wait_ready(1000);
    endtask

    task automatic test_reset_mid();
        int n;
        send(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        n = 0;
        while (lcd_en !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (lcd_en !== 0 || bus.cmd_ready !== 0 || init_done !== 0 || lcd_d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid en=%b rdy=%b done=%b d=%h want 0 0 0 00",
                     lcd_en, bus.cmd_ready, init_done, lcd_d);
        end
        release_reset();
        wait_ready(3000);
        test_data_write();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_rs    = 1'b0;
        bus.cmd_data  = 8'h00;
        fork
            monitor();
        join_none
        test_reset();
        test_data_write();
        test_slow_commands();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (5) step();
        n_cmp++;
        if (exp_q.size() != 0 || exp_rise_q.size() != 0 || exp_fall_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_pulses pending=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog time=%0t want end of test sequence", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
